// File: rtl/grid_cursor_controller.sv
// Button-driven cursor for a COLS x ROWS board: 2-flop synchroniser, debounce,
// one move per press with optional auto-repeat, and wrap or clamp at the edges.
module grid_cursor_controller #(
    parameter int COLS            = 8,
    parameter int ROWS            = 8,
    parameter int XW              = 4,
    parameter int YW              = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 8,
    parameter int WRAP            = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic [3:0]    inputBtn,
    output logic [XW-1:0] outX,
    output logic [YW-1:0] outY,
    output logic          moved,
    output logic          blocked
);

    localparam int DBW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW   = $clog2(RMAX + 1) + 1;
    localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [XW-1:0]  X_MAX     = XW'(COLS - 1);
    localparam logic [YW-1:0]  Y_MAX     = YW'(ROWS - 1);
    localparam logic [HW-1:0]  H_DELAY   = HW'(REPEAT_DELAY);
    localparam logic [HW-1:0]  H_PERIOD  = HW'(REPEAT_PERIOD);
    localparam bit             WRAP_EN   = (WRAP != 0);
    localparam bit             REPEAT_EN = (REPEAT_DELAY > 0);

    function automatic logic cmd_valid(input logic [3:0] b);
        case (b)
            4'b0111, 4'b1011, 4'b1101, 4'b1110: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    logic [3:0]    sync1_q, sync2_q, sync_prev_q, db_q, db_d, db_prev_q;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          rep_q, rep_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          moved_q, moved_d, blocked_q, blocked_d;
    logic          db_changed_s, press_s, repeat_s, step_s;
    logic [HW-1:0] rep_target_s;

    // Debounce: a new sync value must stay put for DEBOUNCE_CYCLES checks before it is accepted.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        if (sync2_q == db_q || sync2_q != sync_prev_q) begin
            db_cnt_d = {DBW{1'b0}};
        end else if (db_cnt_q == DB_LAST) begin
            db_d     = sync2_q;
            db_cnt_d = {DBW{1'b0}};
        end else begin
            db_cnt_d = db_cnt_q + DBW'(1);
        end
    end

    assign db_changed_s = (db_q != db_prev_q);
    assign press_s      = enable && db_changed_s && cmd_valid(db_q);
    assign rep_target_s = rep_q ? H_PERIOD : H_DELAY;
    assign repeat_s     = REPEAT_EN && enable && !db_changed_s && cmd_valid(db_q)
                          && (hold_q != {HW{1'b0}}) && (hold_q == rep_target_s);
    assign step_s       = press_s || repeat_s;

    // Hold counter: nonzero means a command is being held and counts cycles since its last move.
    always_comb begin
        hold_d = hold_q;
        rep_d  = rep_q;
        if (press_s) begin
            hold_d = REPEAT_EN ? HW'(1) : {HW{1'b0}};
            rep_d  = 1'b0;
        end else if (repeat_s) begin
            hold_d = HW'(1);
            rep_d  = 1'b1;
        end else if (!enable || db_changed_s || hold_q == {HW{1'b0}}) begin
            hold_d = {HW{1'b0}};
            rep_d  = 1'b0;
        end else begin
            hold_d = hold_q + HW'(1);
        end
    end

    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        moved_d   = 1'b0;
        blocked_d = 1'b0;
        if (step_s) begin
            case (db_q)
                4'b0111: begin
                    if (y_q != {YW{1'b0}}) begin y_d = y_q - YW'(1); moved_d = 1'b1; end
                    else if (WRAP_EN) begin y_d = Y_MAX; moved_d = 1'b1; end
                    else begin blocked_d = 1'b1; end
                end
                4'b1101: begin
                    if (y_q != Y_MAX) begin y_d = y_q + YW'(1); moved_d = 1'b1; end
                    else if (WRAP_EN) begin y_d = {YW{1'b0}}; moved_d = 1'b1; end
                    else begin blocked_d = 1'b1; end
                end
                4'b1011: begin
                    if (x_q != {XW{1'b0}}) begin x_d = x_q - XW'(1); moved_d = 1'b1; end
                    else if (WRAP_EN) begin x_d = X_MAX; moved_d = 1'b1; end
                    else begin blocked_d = 1'b1; end
                end
                4'b1110: begin
                    if (x_q != X_MAX) begin x_d = x_q + XW'(1); moved_d = 1'b1; end
                    else if (WRAP_EN) begin x_d = {XW{1'b0}}; moved_d = 1'b1; end
                    else begin blocked_d = 1'b1; end
                end
                default: begin
                    moved_d = 1'b0;
                end
            endcase
        end else begin
            moved_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q     <= 4'b1111;
            sync2_q     <= 4'b1111;
            sync_prev_q <= 4'b1111;
            db_q        <= 4'b1111;
            db_prev_q   <= 4'b1111;
            db_cnt_q    <= {DBW{1'b0}};
            hold_q      <= {HW{1'b0}};
            rep_q       <= 1'b0;
            x_q         <= {XW{1'b0}};
            y_q         <= {YW{1'b0}};
            moved_q     <= 1'b0;
            blocked_q   <= 1'b0;
        end else begin
            sync1_q     <= inputBtn;
            sync2_q     <= sync1_q;
            sync_prev_q <= sync2_q;
            db_q        <= db_d;
            db_prev_q   <= db_q;
            db_cnt_q    <= db_cnt_d;
            hold_q      <= hold_d;
            rep_q       <= rep_d;
            x_q         <= x_d;
            y_q         <= y_d;
            moved_q     <= moved_d;
            blocked_q   <= blocked_d;
        end
    end

    assign outX    = x_q;
    assign outY    = y_q;
    assign moved   = moved_q;
    assign blocked = blocked_q;

endmodule

// File: tb/tb_grid_cursor_controller.sv
// Directed bench: dut_a is the default 8x8 wrapping board, dut_b a 5x3 clamping one.
// Expected move/blocked events are queued when stimulus is driven and checked on arrival.
module tb_grid_cursor_controller;

    localparam int LAT = 8;   // from the drive negedge to the negedge after the move edge

    typedef struct {
        int cyc;
        int x;
        int y;
        bit blk;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       en_a, en_b;
    logic [3:0] btn_a, btn_b;
    logic [3:0] x_a, y_a, x_b, y_b;
    logic       moved_a, blocked_a, moved_b, blocked_b;

    int  cyc = 0;
    int  vectors = 0;
    int  miscompares = 0;
    ev_t q_a[$];
    ev_t q_b[$];

    grid_cursor_controller dut_a (
        .clk(clk), .reset(reset), .enable(en_a), .inputBtn(btn_a),
        .outX(x_a), .outY(y_a), .moved(moved_a), .blocked(blocked_a)
    );

    grid_cursor_controller #(.COLS(5), .ROWS(3), .WRAP(0)) dut_b (
        .clk(clk), .reset(reset), .enable(en_b), .inputBtn(btn_b),
        .outX(x_b), .outY(y_b), .moved(moved_b), .blocked(blocked_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every moved/blocked pulse must match the head of its queue.
    always @(negedge clk) begin
        ev_t e;
        if (moved_a === 1'b1 || blocked_a === 1'b1) begin
            if (q_a.size() > 0) e = q_a.pop_front();
            else e = '{-1, 0, 0, 1'b0};
            check("a_evt_cycle", cyc, e.cyc);
            check("a_evt_x", 32'(x_a), e.x);
            check("a_evt_y", 32'(y_a), e.y);
            check("a_evt_moved", 32'(moved_a), 32'(!e.blk));
            check("a_evt_blocked", 32'(blocked_a), 32'(e.blk));
        end
        if (moved_b === 1'b1 || blocked_b === 1'b1) begin
            if (q_b.size() > 0) e = q_b.pop_front();
            else e = '{-1, 0, 0, 1'b0};
            check("b_evt_cycle", cyc, e.cyc);
            check("b_evt_x", 32'(x_b), e.x);
            check("b_evt_y", 32'(y_b), e.y);
            check("b_evt_moved", 32'(moved_b), 32'(!e.blk));
            check("b_evt_blocked", 32'(blocked_b), 32'(e.blk));
        end
    end

    task automatic expect_pos(input bit sel, input int ex, input int ey);
        if (sel) begin
            check("b_pending", q_b.size(), 0);
            check("b_outX", 32'(x_b), ex);
            check("b_outY", 32'(y_b), ey);
        end else begin
            check("a_pending", q_a.size(), 0);
            check("a_outX", 32'(x_a), ex);
            check("a_outY", 32'(y_a), ey);
        end
    endtask

    // One clean press held 12 cycles then released; the release is allowed to settle.
    task automatic tap(input bit sel, input logic [3:0] b, input bit expect_evt,
                       input int ex, input int ey, input bit blk);
        int c;
        @(negedge clk);
        c = cyc;
        if (sel) btn_b = b;
        else btn_a = b;
        if (expect_evt) begin
            if (sel) q_b.push_back('{c + LAT, ex, ey, blk});
            else q_a.push_back('{c + LAT, ex, ey, blk});
        end
        repeat (12) @(negedge clk);
        if (sel) btn_b = 4'b1111;
        else btn_a = 4'b1111;
        repeat (12) @(negedge clk);
        expect_pos(sel, ex, ey);
    endtask

    initial begin
        int c;
        reset = 1'b0;
        en_a  = 1'b1;
        en_b  = 1'b1;
        btn_a = 4'b1110;
        btn_b = 4'b1111;

        // Reset held three edges with right pressed on dut_a.
        repeat (3) @(negedge clk);
        check("rst_a_outX", 32'(x_a), 0);
        check("rst_a_outY", 32'(y_a), 0);
        check("rst_a_moved", 32'(moved_a), 0);
        check("rst_a_blocked", 32'(blocked_a), 0);
        check("rst_b_outX", 32'(x_b), 0);
        check("rst_b_outY", 32'(y_b), 0);

        // Release reset with the button still held: one move at standard latency.
        c = cyc;
        reset = 1'b1;
        q_a.push_back('{c + LAT, 1, 0, 1'b0});
        repeat (12) @(negedge clk);
        btn_a = 4'b1111;
        repeat (12) @(negedge clk);
        expect_pos(1'b0, 1, 0);

        // Wrapping on the 8x8 board.
        tap(1'b0, 4'b1011, 1'b1, 0, 0, 1'b0);
        tap(1'b0, 4'b0111, 1'b1, 0, 7, 1'b0);
        tap(1'b0, 4'b1011, 1'b1, 7, 7, 1'b0);
        tap(1'b0, 4'b1110, 1'b1, 0, 7, 1'b0);
        tap(1'b0, 4'b1101, 1'b1, 0, 0, 1'b0);

        // Clamping on the 5x3 board.
        tap(1'b1, 4'b0111, 1'b1, 0, 0, 1'b1);
        for (int i = 1; i <= 4; i++) tap(1'b1, 4'b1110, 1'b1, i, 0, 1'b0);
        tap(1'b1, 4'b1110, 1'b1, 4, 0, 1'b1);
        tap(1'b1, 4'b1101, 1'b1, 4, 1, 1'b0);
        tap(1'b1, 4'b1101, 1'b1, 4, 2, 1'b0);
        tap(1'b1, 4'b1101, 1'b1, 4, 2, 1'b1);

        // Three-cycle glitch is rejected.
        @(negedge clk);
        btn_a = 4'b1101;
        repeat (3) @(negedge clk);
        btn_a = 4'b1111;
        repeat (15) @(negedge clk);
        expect_pos(1'b0, 0, 0);

        // Bouncing, then stable: exactly one move timed from the last edge of the bounce.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            btn_a = (i % 2 == 0) ? 4'b1101 : 4'b1111;
        end
        tap(1'b0, 4'b1101, 1'b1, 0, 1, 1'b0);
        tap(1'b0, 4'b0111, 1'b1, 0, 0, 1'b0);

        // Auto-repeat: hold right 52 cycles; debounced release lands at c+59.
        @(negedge clk);
        c = cyc;
        btn_a = 4'b1110;
        q_a.push_back('{c + LAT, 1, 0, 1'b0});
        for (int k = 0; k < 5; k++) q_a.push_back('{c + LAT + 16 + 8 * k, 2 + k, 0, 1'b0});
        repeat (52) @(negedge clk);
        btn_a = 4'b1111;
        repeat (16) @(negedge clk);
        expect_pos(1'b0, 6, 0);

        // Multi-button patterns never move.
        @(negedge clk);
        btn_a = 4'b0110;
        repeat (20) @(negedge clk);
        btn_a = 4'b0000;
        repeat (20) @(negedge clk);
        btn_a = 4'b1111;
        repeat (12) @(negedge clk);
        expect_pos(1'b0, 6, 0);

        // Press while disabled is dropped; enabling while held does not move.
        en_a = 1'b0;
        btn_a = 4'b1011;
        repeat (14) @(negedge clk);
        expect_pos(1'b0, 6, 0);
        en_a = 1'b1;
        repeat (30) @(negedge clk);
        expect_pos(1'b0, 6, 0);
        btn_a = 4'b1111;
        repeat (12) @(negedge clk);
        tap(1'b0, 4'b1011, 1'b1, 5, 0, 1'b0);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
